// File: rtl/fetch_stage.sv
// fetch_stage: PC owner and instruction fetch with one outstanding request,
// one-entry stall buffer and the F/D pipeline register feeding decode.
module fetch_stage #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [DATA_W-1:0] NOP_INSTR = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall_i,
    input  logic              redirect_i,
    input  logic [ADDR_W-1:0] redirect_pc_i,
    output logic              imem_req_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    input  logic              imem_rvalid_i,
    input  logic [DATA_W-1:0] imem_rdata_i,
    output logic [DATA_W-1:0] instruction_out,
    output logic [ADDR_W-1:0] pc_out,
    output logic [ADDR_W-1:0] pc_plus1_out,
    output logic              valid_out
);
    localparam logic [1:0] ISSUE = 2'd0, WAIT = 2'd1, HOLD = 2'd2;
    logic [1:0]        state, state_next;
    logic              drop;
    logic [ADDR_W-1:0] pc, pc_inc, buf_pc;
    logic [DATA_W-1:0] buf_instr;
    logic              accept, capture, unload;
    assign pc_inc  = pc + ADDR_W'(1);
    assign accept  = state == WAIT && imem_rvalid_i && !drop && !stall_i && !redirect_i;
    assign capture = state == WAIT && imem_rvalid_i && !drop && stall_i && !redirect_i;
    assign unload  = state == HOLD && !stall_i && !redirect_i;
    // An accept re-requests in the same cycle from the incremented PC for 1/cycle throughput.
    assign imem_req_o  = rst_n && !redirect_i && (state == ISSUE || accept);
    assign imem_addr_o = accept ? pc_inc : pc;
    always_comb begin
        state_next = state == ISSUE ? (redirect_i ? ISSUE : WAIT)
                   : state == WAIT  ? (!imem_rvalid_i ? WAIT
                                      : (drop || redirect_i) ? ISSUE
                                      : stall_i ? HOLD : WAIT)
                   : (redirect_i || !stall_i) ? ISSUE : HOLD;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= ISSUE;
            pc              <= RESET_PC;
            drop            <= 1'b0;
            buf_instr       <= NOP_INSTR;
            buf_pc          <= '0;
            instruction_out <= NOP_INSTR;
            pc_out          <= '0;
            pc_plus1_out    <= '0;
            valid_out       <= 1'b0;
        end else begin
            state <= state_next;
            if (redirect_i)
                pc <= redirect_pc_i;
            else if (accept || capture)
                pc <= pc_inc;
            // A redirect with the response still in flight must swallow it later.
            if (state == WAIT && imem_rvalid_i)
                drop <= 1'b0;
            else if (state == WAIT && redirect_i)
                drop <= 1'b1;
            if (capture) begin
                buf_instr <= imem_rdata_i;
                buf_pc    <= pc;
            end
            if (redirect_i) begin
                valid_out       <= 1'b0;
                instruction_out <= NOP_INSTR;
            end else if (accept) begin
                instruction_out <= imem_rdata_i;
                pc_out          <= pc;
                pc_plus1_out    <= pc_inc;
                valid_out       <= 1'b1;
            end else if (unload) begin
                instruction_out <= buf_instr;
                pc_out          <= buf_pc;
                pc_plus1_out    <= buf_pc + ADDR_W'(1);
                valid_out       <= 1'b1;
            end else if (!stall_i) begin
                valid_out       <= 1'b0;
                instruction_out <= NOP_INSTR;
            end
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed cycle-by-cycle checks of fetch_stage against a
// variable-latency instruction memory model.
module tb_fetch_stage;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall_i = 1'b0;
    logic        redirect_i = 1'b0;
    logic [15:0] redirect_pc_i = '0;
    logic        imem_req_o;
    logic [15:0] imem_addr_o;
    logic        imem_rvalid_i = 1'b0;
    logic [15:0] imem_rdata_i = '0;
    logic [15:0] instruction_out, pc_out, pc_plus1_out;
    logic        valid_out;
    int vectors = 0;
    int miscompares = 0;
    int lat = 1;
    int cnt = 0;
    logic busy = 1'b0;
    logic [15:0] paddr = '0;

    fetch_stage dut (
        .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .redirect_i(redirect_i),
        .redirect_pc_i(redirect_pc_i), .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
        .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
        .instruction_out(instruction_out), .pc_out(pc_out), .pc_plus1_out(pc_plus1_out),
        .valid_out(valid_out)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mem_rd(input logic [15:0] a);
        case (a)
            16'h0000: return 16'h8107;
            16'h0001: return 16'h8209;
            16'h0002: return 16'h1012;
            16'h0004: return 16'h5005;
            default:  return {8'hE0, a[7:0]};
        endcase
    endfunction

    // Response for a request seen at edge n is valid during cycle n+lat.
    always @(posedge clk) begin
        if (imem_req_o) begin
            paddr = imem_addr_o;
            cnt   = lat;
            busy  = 1'b1;
        end
        if (busy && cnt == 1) begin
            imem_rvalid_i <= 1'b1;
            imem_rdata_i  <= mem_rd(paddr);
            busy = 1'b0;
        end else begin
            imem_rvalid_i <= 1'b0;
            if (busy) cnt--;
        end
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk_fd(input string tag, input logic [15:0] i, input logic [15:0] p, input logic v);
        chk({tag, "_instr"}, instruction_out, i);
        chk({tag, "_pc"}, pc_out, p);
        chk({tag, "_pc1"}, pc_plus1_out, p + 16'd1);
        chk({tag, "_valid"}, {15'd0, valid_out}, {15'd0, v});
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_valid"}, {15'd0, valid_out}, 16'd0);
        chk({tag, "_instr"}, instruction_out, 16'h0000);
        chk({tag, "_pc"}, pc_out, 16'h0000);
        chk({tag, "_pc1"}, pc_plus1_out, 16'h0000);
        chk({tag, "_req"}, {15'd0, imem_req_o}, 16'd0);
    endtask

    task automatic chk_req(input string tag, input logic r, input logic [15:0] a);
        chk({tag, "_req"}, {15'd0, imem_req_o}, {15'd0, r});
        if (r) chk({tag, "_addr"}, imem_addr_o, a);
    endtask

    initial begin
        #3;
        chk_reset("rst");
        @(posedge clk); #2;
        rst_n = 1'b1; #1;
        chk_req("c0", 1, 16'h0000);
        tick(); chk_req("c1", 1, 16'h0001);
        chk("c1_valid", {15'd0, valid_out}, 16'd0);
        tick(); chk_fd("c2", 16'h8107, 16'h0000, 1); chk_req("c2", 1, 16'h0002);
        tick(); chk_fd("c3", 16'h8209, 16'h0001, 1); chk_req("c3", 1, 16'h0003);
        lat = 3;
        tick(); chk_fd("c4", 16'h1012, 16'h0002, 1); chk_req("c4", 0, 16'h0000);
        tick(); chk("c5_valid", {15'd0, valid_out}, 16'd0);
        chk("c5_nop", instruction_out, 16'h0000); chk_req("c5", 0, 16'h0000);
        tick(); chk_req("c6", 1, 16'h0004);
        tick(); chk_fd("c7", 16'hE003, 16'h0003, 1);
        stall_i = 1'b1; #1;
        chk_req("c7", 0, 16'h0000);
        tick(); chk_req("c8", 0, 16'h0000);
        tick(); chk_req("c9_resp", 0, 16'h0000);
        tick(); chk_req("c10_hold", 0, 16'h0000); chk_fd("c10_hold", 16'hE003, 16'h0003, 1);
        tick(); stall_i = 1'b0; #1;
        chk_req("c11_unload", 0, 16'h0000);
        tick(); chk_fd("c12", 16'h5005, 16'h0004, 1); chk_req("c12", 1, 16'h0005);
        repeat (3) tick();
        chk_req("c15", 1, 16'h0006);
        repeat (3) tick();
        chk_req("c18", 1, 16'h0007);
        chk("c18_valid", {15'd0, valid_out}, 16'd0);
        tick(); chk_fd("c19", 16'hE006, 16'h0006, 1);
        redirect_i = 1'b1; redirect_pc_i = 16'h0020; #1;
        chk_req("c19_redir", 0, 16'h0000);
        tick(); redirect_i = 1'b0; #1;
        chk("c20_valid", {15'd0, valid_out}, 16'd0);
        chk("c20_nop", instruction_out, 16'h0000);
        chk_req("c20_drop", 0, 16'h0000);
        tick(); chk_req("c21_stale", 0, 16'h0000);
        chk("c21_valid", {15'd0, valid_out}, 16'd0);
        lat = 1;
        tick(); chk_req("c22", 1, 16'h0020);
        tick(); chk_req("c23", 1, 16'h0021);
        tick(); chk_fd("c24", 16'hE020, 16'h0020, 1);
        redirect_i = 1'b1; stall_i = 1'b1; redirect_pc_i = 16'hFFFF; #1;
        chk_req("c24_redir", 0, 16'h0000);
        tick(); redirect_i = 1'b0; stall_i = 1'b0; #1;
        chk("c25_valid", {15'd0, valid_out}, 16'd0);
        chk("c25_nop", instruction_out, 16'h0000);
        chk_req("c25", 1, 16'hFFFF);
        tick(); chk_req("c26_wrap", 1, 16'h0000);
        tick(); chk_fd("c27", 16'hE0FF, 16'hFFFF, 1);
        chk("c27_pc1_wrap", pc_plus1_out, 16'h0000);
        lat = 3;
        tick(); chk_fd("c28", 16'h8107, 16'h0000, 1); chk_req("c28", 0, 16'h0000);
        rst_n = 1'b0; lat = 1; #1;
        chk_reset("rst_mid");
        tick();
        tick(); rst_n = 1'b1; #1;
        chk_req("c30_restart", 1, 16'h0000);
        chk("c30_valid", {15'd0, valid_out}, 16'd0);
        tick(); chk("c31_valid", {15'd0, valid_out}, 16'd0);
        chk_req("c31", 1, 16'h0001);
        tick(); chk_fd("c32", 16'h8107, 16'h0000, 1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
